spi_slave: RTL and testbench
============================

# spi_slave

SPI slave (responder) endpoint that pairs with `spi_master` on the same link. It oversamples `sclk`, `csn` and `mosi` in the local `clk` domain and shifts in one `DATA_WIDTH` word, MSB first. In the same transfer it shifts out a word on `miso`, and it pulses `spi_done` with the received word on `data_recv`. It sits on the peripheral side of the serial-protocol test system and is used as the loopback target for master benches.

## Interface
- `DATA_WIDTH`, 8: bits per word.
- `CPOL`, 0: sclk idle level. 0 means idle low, 1 means idle high.
- `CPHA`, 0: clock phase. 0 means sample on the leading edge and shift on the trailing edge. 1 means shift on the leading edge and sample on the trailing edge.
- `clk` in 1: system clock, all logic on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from master, asynchronous to `clk`.
- `csn` in 1: chip select, active low, asynchronous.
- `mosi` in 1: serial data from master.
- `miso` out 1: serial data to master.
- `data_send` in DATA_WIDTH: word to transmit. Captured at transfer start and at each word boundary.
- `data_recv` out DATA_WIDTH: last complete received word. Held until the next complete word.
- `spi_done` out 1: one-`clk` pulse when a full word has been received.
- `busy` out 1: high while synchronized `csn` is low.

## Operation
- Synchronizer:
  - `sclk`, `csn` and `mosi` each pass through 2 flops, then one history flop for edge detection.
  - All decisions use the synchronized signals only.
- Edge decode:
  - leading edge = sclk rising if CPOL=0, falling if CPOL=1.
  - trailing edge = the opposite edge.
  - sample edge = leading if CPHA=0, trailing if CPHA=1. shift edge = the other edge.
- States:
  - IDLE: `csn` high. Bit counter is 0 and `miso` is idle.
  - ACTIVE: entered on the synchronized `csn` falling edge.
    - `data_send` is loaded into the tx shift register.
    - CPHA=0: the MSB drives `miso` immediately.
    - CPHA=1: `miso` holds its previous value until the first shift edge, which presents the MSB.
    - Each sample edge shifts the sync'd `mosi` into the rx register, LSB position, MSB first, and increments the counter.
    - Each shift edge moves the next tx bit onto `miso`. For CPHA=0 the first shift edge after the last sample of a word is a word-boundary reload (see below), not a bit advance.
  - Word complete: on the sample edge where the counter reaches DATA_WIDTH:
    - next cycle, `data_recv` takes the rx word and `spi_done` is 1 for one cycle.
    - the counter wraps to 0.
    - the tx register reloads from `data_send` at the next shift edge (CPHA=0) or at the next leading edge (CPHA=1). This supports back-to-back words with `csn` held low.
  - Abort: `csn` rising before the counter reaches DATA_WIDTH returns to IDLE. No `spi_done`, `data_recv` unchanged, partial rx discarded.
  - `csn` rising in the same cycle as a final sample edge: the word completes (`spi_done` asserts), then the block goes to IDLE.
- Reset:
  - `rstn` low at any time, including mid-word, forces IDLE immediately.
  - Reset values: `data_recv`=0, `spi_done`=0, `busy`=0, `miso`=0 (Z with the tristate option), all sync flops equal to their idle levels (sclk=CPOL, csn=1).

## Timing
- Pin-to-internal latency: 3 `clk` cycles for a `sclk`/`csn` edge.
- `miso` changes 3 `clk` cycles after the causing pin edge.
- `spi_done` asserts 4 cycles after the final sample-edge pin transition.
- Constraint: each sclk half-period ≥ 4 `clk` cycles (the system runs sclk = clk/10 → 5 cycles).
- Constraint: `csn`-low to first sclk edge ≥ 4 cycles.
- `data_send` must be stable from `spi_done` until the next reload point.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN`:
  - Defined: `miso` is 1'bz whenever `busy`=0, including during reset, and is driven only in ACTIVE.
  - Undefined: `miso` is driven 0 in IDLE and during reset.

## Test plan
- Mode 0 (CPOL=0, CPHA=0), clk 50 MHz, sclk 5 MHz, master sends 8'hA5, `data_send`=8'h3C → `data_recv`=8'hA5, one `spi_done` pulse, master receives 8'h3C.
- Mode 3 (CPOL=1, CPHA=1), master sends 8'b10011010, `data_send`=8'h81 → `data_recv`=8'h9A, master receives 8'h81.
- Back-to-back: `csn` held low for 16 bits with 8'h12 then 8'h34, `data_send` 8'hF0 then 8'h0F → two `spi_done` pulses, `data_recv` 8'h12 then 8'h34, master receives 8'hF0 then 8'h0F.
- Abort: `csn` raised after 4 bits of 8'hFF → no `spi_done`, `data_recv` keeps its prior value. The next full transfer of 8'h55 gives `data_recv`=8'h55.
- Reset mid-word: `rstn` pulsed low after 5 bits → all outputs return to reset values within the same cycle. The next transfer of 8'hC3 completes correctly.
- With `SPI_SLAVE_MISO_TRISTATE_EN` defined → `miso`=Z while `csn`=1 and driven while `csn`=0. Without it → `miso`=0 while idle.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI responder endpoint. Oversamples sclk/csn/mosi in the clk
// domain, shifts one DATA_WIDTH word in (MSB first) while shifting a word out
// on miso, and pulses spi_done with the received word on data_recv.
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to float miso (1'bz)
// whenever the slave is not busy; otherwise miso is driven 0 while idle.
// Handshake: there is no valid/ready pair; spi_done is a one-cycle strobe
// meaning data_recv has just been updated, and data_send is sampled only at
// transfer start and at each word-boundary reload point.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_send,
    output logic [DATA_WIDTH-1:0] data_recv,
    output logic                  spi_done,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nxt;

    logic sclk_s1, sclk_s2, sclk_h;
    logic csn_s1, csn_s2, csn_h;
    logic mosi_s1, mosi_s2, mosi_h;

    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] shift_src;
    logic                  miso_q;
    logic                  reload;
    logic                  done_pend;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, csn_fall, csn_rise, last_bit;

    // Two-flop synchronizers plus one history flop per pin; reset to idle levels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_h  <= CPOL;
            csn_s1  <= 1'b1;
            csn_s2  <= 1'b1;
            csn_h   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            mosi_h  <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            csn_s1  <= csn;
            csn_s2  <= csn_s1;
            csn_h   <= csn_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            mosi_h  <= mosi_s2;
        end
    end

    assign sclk_rise   = sclk_s2 & ~sclk_h;
    assign sclk_fall   = ~sclk_s2 & sclk_h;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign csn_fall    = csn_h & ~csn_s2;
    assign csn_rise    = ~csn_h & csn_s2;
    assign last_bit    = (bit_cnt == CW'(DATA_WIDTH - 1));

    // At a word boundary the next shift edge takes a fresh word from data_send.
    assign shift_src   = reload ? data_send : tx_sr;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: csn low selects ACTIVE, csn high returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csn_fall) state_nxt = ACTIVE;
            ACTIVE:  if (csn_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift datapath: rx capture on sample edges, tx presentation on shift edges.
    // tx_sr holds the bits still to be presented; miso_q is the bit on the wire.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            miso_q    <= 1'b0;
            reload    <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            done_pend <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                reload  <= 1'b0;
                if (csn_fall) begin
                    if (!CPHA) begin
                        miso_q <= data_send[DATA_WIDTH-1];
                        tx_sr  <= {data_send[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        tx_sr  <= data_send;
                    end
                end
            end else begin
                if (sample_edge) begin
                    rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_h};
                    if (last_bit) begin
                        bit_cnt   <= '0;
                        done_pend <= 1'b1;
                        reload    <= 1'b1;
                    end else begin
                        bit_cnt   <= bit_cnt + CW'(1);
                    end
                end
                if (shift_edge) begin
                    miso_q <= shift_src[DATA_WIDTH-1];
                    tx_sr  <= {shift_src[DATA_WIDTH-2:0], 1'b0};
                    reload <= 1'b0;
                end
                // A final sample in this same cycle still completes its word.
                if (csn_rise) begin
                    bit_cnt <= '0;
                    reload  <= 1'b0;
                end
            end
        end
    end

    // Publish the completed word one cycle after its final sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_recv <= '0;
            spi_done  <= 1'b0;
        end else begin
            spi_done <= done_pend;
            if (done_pend) data_recv <= rx_sr;
        end
    end

    assign busy = (state == ACTIVE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = busy ? miso_q : 1'bz;
`else
    assign miso = busy ? miso_q : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives a mode-0 and a mode-3 spi_slave from a bench SPI
// master; checks received words, master-side readback, busy and idle miso.
module tb_spi_slave;

    localparam int H = 5;   // sclk half period in clk cycles

    logic clk = 1'b0;
    logic rstn;
    logic mode3;
    logic m_sclk, m_csn, m_mosi;
    logic [7:0] data_send;

    wire sclk0 = mode3 ? 1'b0 : m_sclk;
    wire csn0  = mode3 ? 1'b1 : m_csn;
    wire sclk3 = mode3 ? m_sclk : 1'b1;
    wire csn3  = mode3 ? m_csn : 1'b1;

    wire       miso0, miso3, done0, done3, busy0, busy3;
    wire [7:0] recv0, recv3;

    wire       m_miso = mode3 ? miso3 : miso0;
    wire       m_done = mode3 ? done3 : done0;
    wire       m_busy = mode3 ? busy3 : busy0;
    wire [7:0] m_recv = mode3 ? recv3 : recv0;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_exp = 0;
    logic idle_miso;
    logic [7:0] exp_q[$];
    logic [7:0] tx_words[$];
    logic [7:0] ds_words[$];
    logic [7:0] rx_words[$];
    logic [7:0] last_recv[2];

    spi_slave u_m0 (
        .clk(clk), .rstn(rstn), .sclk(sclk0), .csn(csn0), .mosi(m_mosi),
        .miso(miso0), .data_send(data_send), .data_recv(recv0),
        .spi_done(done0), .busy(busy0)
    );

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .rstn(rstn), .sclk(sclk3), .csn(csn3), .mosi(m_mosi),
        .miso(miso3), .data_send(data_send), .data_recv(recv3),
        .spi_done(done3), .busy(busy3)
    );

    // clock
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // scoreboard: every spi_done must carry the next expected master word
    always @(negedge clk) begin
        if (rstn && m_done) begin
            n_done++;
            if (exp_q.size() > 0) check("recv", m_recv, exp_q.pop_front());
        end
    end

    task automatic set_mode(input logic m);
        mode3  = m;
        m_sclk = m;
        m_csn  = 1'b1;
        wait_clk(4);
    endtask

    // master driver: shifts tx_words out, collects miso into rx_words;
    // stop_bits>0 ends early, by csn rise or by a reset pulse
    task automatic run_xfer(input int stop_bits, input logic do_reset);
        logic [7:0] r;
        logic bits[$];
        int nb, k, bp;
        bits.delete();
        rx_words.delete();
        foreach (tx_words[i])
            for (int b = 7; b >= 0; b--) bits.push_back(tx_words[i][b]);
        nb = (stop_bits > 0) ? stop_bits : bits.size();
        r = 8'h00;
        data_send = ds_words[0];
        m_csn = 1'b0;
        if (!mode3) m_mosi = bits[0];
        wait_clk(H);
        check("busy_active", m_busy, 1'b1);
        for (int i = 0; i < nb; i++) begin
            k  = i / 8;
            bp = 7 - (i % 8);
            if (!mode3) begin
                m_sclk = 1'b1;
                r[bp]  = m_miso;
                if (bp == 0 && k + 1 < ds_words.size()) data_send = ds_words[k+1];
                wait_clk(H);
                m_sclk = 1'b0;
                if (i + 1 < nb) m_mosi = bits[i+1];
                wait_clk(H);
            end else begin
                m_sclk = 1'b0;
                m_mosi = bits[i];
                wait_clk(H);
                m_sclk = 1'b1;
                r[bp]  = m_miso;
                if (bp == 0 && k + 1 < ds_words.size()) data_send = ds_words[k+1];
                wait_clk(H);
            end
            if (bp == 0) rx_words.push_back(r);
        end
        if (do_reset) begin
            rstn = 1'b0;
            #1;
            check("rst_recv", m_recv, 8'h00);
            check("rst_done", m_done, 1'b0);
            check("rst_busy", m_busy, 1'b0);
            check("rst_miso", m_miso, idle_miso);
            m_csn  = 1'b1;
            m_sclk = mode3;
            wait_clk(3);
            rstn = 1'b1;
            last_recv[0] = 8'h00;
            last_recv[1] = 8'h00;
            wait_clk(4);
        end else begin
            m_csn = 1'b1;
            wait_clk(H);
            check("busy_idle", m_busy, 1'b0);
            check("miso_idle", m_miso, idle_miso);
            wait_clk($urandom_range(2, 6));
        end
    endtask

    // full transfer against the model: slave gets tx_words, master gets ds_words
    task automatic do_full();
        foreach (tx_words[i]) exp_q.push_back(tx_words[i]);
        n_exp += tx_words.size();
        run_xfer(0, 1'b0);
        check("rx_count", rx_words.size(), ds_words.size());
        foreach (rx_words[i]) check("master_rx", rx_words[i], ds_words[i]);
        check("done_cnt", n_done, n_exp);
        last_recv[mode3] = tx_words[tx_words.size()-1];
        check("recv_hold", m_recv, last_recv[mode3]);
    endtask

    task automatic do_abort(input int nbits);
        run_xfer(nbits, 1'b0);
        check("abort_done_cnt", n_done, n_exp);
        check("abort_recv", m_recv, last_recv[mode3]);
    endtask

    task automatic fill_random(input int n);
        tx_words.delete();
        ds_words.delete();
        for (int i = 0; i < n; i++) begin
            tx_words.push_back(8'($urandom_range(0, 255)));
            ds_words.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        idle_miso = 1'bz;
`else
        idle_miso = 1'b0;
`endif
        last_recv[0] = 8'h00;
        last_recv[1] = 8'h00;
        mode3 = 1'b0; m_sclk = 1'b0; m_csn = 1'b1; m_mosi = 1'b0;
        data_send = 8'h00;
        rstn = 1'b0;
        wait_clk(2);
        check("reset_recv0", recv0, 8'h00);
        check("reset_done0", done0, 1'b0);
        check("reset_busy0", busy0, 1'b0);
        check("reset_miso0", miso0, idle_miso);
        check("reset_recv3", recv3, 8'h00);
        check("reset_miso3", miso3, idle_miso);
        rstn = 1'b1;
        wait_clk(4);

        // mode 0 single word
        tx_words = '{8'hA5}; ds_words = '{8'h3C};
        do_full();

        // mode 3 single word
        set_mode(1'b1);
        tx_words = '{8'h9A}; ds_words = '{8'h81};
        do_full();

        // mode 0 back-to-back words with csn held low
        set_mode(1'b0);
        tx_words = '{8'h12, 8'h34}; ds_words = '{8'hF0, 8'h0F};
        do_full();

        // abort after 4 bits, then a full word
        tx_words = '{8'hFF}; ds_words = '{8'hAA};
        do_abort(4);
        tx_words = '{8'h55}; ds_words = '{8'h96};
        do_full();

        // reset after 5 bits, then a full word
        tx_words = '{8'hC3}; ds_words = '{8'h5A};
        run_xfer(5, 1'b1);
        check("post_rst_recv", m_recv, 8'h00);
        tx_words = '{8'hC3}; ds_words = '{8'h7E};
        do_full();

        // randomized traffic in both modes, with occasional aborts
        for (int m = 0; m < 2; m++) begin
            set_mode(m[0]);
            for (int t = 0; t < 10; t++) begin
                fill_random($urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0) do_abort($urandom_range(1, 7));
                else                           do_full();
            end
        end

        wait_clk(10);
        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
